// File: rtl/cache_pkg.sv
// Shared types and address-split helpers for the set-associative write-back cache.
package cache_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StWback,
    StRefill,
    StResp
  } state_e;

  // Widest tag any legal geometry needs (one offset bit, one index bit).
  localparam int unsigned TagMaxW = 28;

  // Line data lives in a parallel array because its width depends on WORDS.
  typedef struct packed {
    logic               valid;
    logic               dirty;
    logic [TagMaxW-1:0] tag;
  } entry_t;

  function automatic int unsigned off_w(input int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_w(input int unsigned sets, input int unsigned words);
    return 30 - off_w(words) - idx_w(sets);
  endfunction

endpackage

// File: rtl/lru_ages.sv
// Per-set LRU ages: age 0 is most recent, age WAYS-1 is the replacement victim.
module lru_ages #(
  parameter  int unsigned WAYS = 4,
  parameter  int unsigned SETS = 16,
  localparam int unsigned WayW = $clog2(WAYS),
  localparam int unsigned IdxW = $clog2(SETS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IdxW-1:0] set_i,
  input  logic            touch_i,
  input  logic [WayW-1:0] touch_way_i,
  output logic [WayW-1:0] victim_o
);

  logic [WayW-1:0] age_q [SETS][WAYS];
  logic [WayW-1:0] row_d [WAYS];

  // Ways younger than the touched one age by one; the rest keep their age.
  always_comb begin
    for (int w = 0; w < int'(WAYS); w++) begin
      row_d[w] = age_q[set_i][w];
      if (WayW'(w) == touch_way_i) begin
        row_d[w] = '0;
      end else if (age_q[set_i][w] < age_q[set_i][touch_way_i]) begin
        row_d[w] = age_q[set_i][w] + 1'b1;
      end
    end
  end

  always_comb begin
    victim_o = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (age_q[set_i][w] == WayW'(WAYS - 1)) victim_o = WayW'(w);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(SETS); s++) begin
        for (int w = 0; w < int'(WAYS); w++) begin
          age_q[s][w] <= WayW'(w);
        end
      end
    end else if (touch_i) begin
      for (int w = 0; w < int'(WAYS); w++) begin
        age_q[set_i][w] <= row_d[w];
      end
    end
  end

endmodule

// File: rtl/nway_cache.sv
// N-way set-associative, write-allocate, write-back cache with line-granular memory port.
module nway_cache
  import cache_pkg::*;
#(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned SETS  = 16,
  parameter int unsigned WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [31:0]           req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  resp_valid_o,
  output logic                  resp_hit_o,
  output logic [31:0]           resp_rdata_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic                  mem_req_we_o,
  output logic [31:0]           mem_req_addr_o,
  output logic [32*WORDS-1:0]   mem_wdata_o,
  input  logic                  mem_resp_valid_i,
  input  logic [32*WORDS-1:0]   mem_rdata_i
);

  localparam int unsigned OffW  = off_w(WORDS);
  localparam int unsigned IdxW  = idx_w(SETS);
  localparam int unsigned TagW  = tag_w(SETS, WORDS);
  localparam int unsigned WayW  = $clog2(WAYS);
  localparam int unsigned LineW = 32 * WORDS;

  state_e          state_q, state_d;
  logic [31:2]     addr_q, addr_d;
  logic            we_q, we_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [WayW-1:0] way_q, way_d;
  logic            hit_q, hit_d;
  logic            sent_q, sent_d;

  entry_t           meta_q [WAYS][SETS];
  logic [LineW-1:0] line_q [WAYS][SETS];

  logic [OffW-1:0] off;
  logic [IdxW-1:0] idx;
  logic [TagW-1:0] tag;
  logic            unused_byte;

  assign off         = addr_q[OffW+1:2];
  assign idx         = addr_q[OffW+2 +: IdxW];
  assign tag         = addr_q[31 -: TagW];
  assign unused_byte = ^req_addr_i[1:0];

  logic            hit, inv_found;
  logic [WayW-1:0] hit_way, inv_way, lru_victim, victim;

  // Descending scan so the lowest-index match wins.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (meta_q[w][idx].valid && (meta_q[w][idx].tag[TagW-1:0] == tag)) begin
        hit     = 1'b1;
        hit_way = WayW'(w);
      end
      if (!meta_q[w][idx].valid) begin
        inv_found = 1'b1;
        inv_way   = WayW'(w);
      end
    end
  end

  assign victim = inv_found ? inv_way : lru_victim;

  logic             meta_we, line_we, touch;
  entry_t           meta_wdata;
  logic [WayW-1:0]  wr_way;
  logic [LineW-1:0] line_base, line_wdata;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    we_d            = we_q;
    wdata_d         = wdata_q;
    way_d           = way_q;
    hit_d           = hit_q;
    sent_d          = sent_q;
    req_ready_o     = 1'b0;
    resp_valid_o    = 1'b0;
    resp_hit_o      = 1'b0;
    resp_rdata_o    = '0;
    mem_req_valid_o = 1'b0;
    mem_req_we_o    = 1'b0;
    mem_req_addr_o  = '0;
    mem_wdata_o     = '0;
    meta_we         = 1'b0;
    meta_wdata      = '0;
    wr_way          = way_q;
    line_we         = 1'b0;
    line_base       = mem_rdata_i;
    touch           = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          addr_d  = req_addr_i[31:2];
          we_d    = req_we_i;
          wdata_d = req_wdata_i;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (hit) begin
          way_d   = hit_way;
          hit_d   = 1'b1;
          wr_way  = hit_way;
          touch   = 1'b1;
          state_d = StResp;
          if (we_q) begin
            meta_we          = 1'b1;
            meta_wdata       = meta_q[hit_way][idx];
            meta_wdata.dirty = 1'b1;
            line_we          = 1'b1;
            line_base        = line_q[hit_way][idx];
          end
        end else begin
          way_d   = victim;
          hit_d   = 1'b0;
          sent_d  = 1'b0;
          state_d = (meta_q[victim][idx].valid && meta_q[victim][idx].dirty) ? StWback
                                                                             : StRefill;
        end
      end
      StWback: begin
        mem_req_valid_o = 1'b1;
        mem_req_we_o    = 1'b1;
        mem_req_addr_o  = {meta_q[way_q][idx].tag[TagW-1:0], idx, {(OffW + 2){1'b0}}};
        mem_wdata_o     = line_q[way_q][idx];
        if (mem_req_ready_i) state_d = StRefill;
      end
      StRefill: begin
        if (!sent_q) begin
          mem_req_valid_o = 1'b1;
          mem_req_addr_o  = {addr_q[31:OffW+2], {(OffW + 2){1'b0}}};
          if (mem_req_ready_i) sent_d = 1'b1;
        end else if (mem_resp_valid_i) begin
          meta_we          = 1'b1;
          meta_wdata.valid = 1'b1;
          meta_wdata.dirty = we_q;
          meta_wdata.tag   = TagMaxW'(tag);
          line_we          = 1'b1;
          touch            = 1'b1;
          state_d          = StResp;
        end
      end
      StResp: begin
        resp_valid_o = 1'b1;
        resp_hit_o   = hit_q;
        resp_rdata_o = line_q[way_q][idx][{off, 5'b0} +: 32];
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Writes merge the store word into either the resident or the refilled line.
    line_wdata = line_base;
    if (we_q) line_wdata[{off, 5'b0} +: 32] = wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      way_q   <= '0;
      hit_q   <= 1'b0;
      sent_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      way_q   <= way_d;
      hit_q   <= hit_d;
      sent_q  <= sent_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < int'(WAYS); w++) begin
        for (int s = 0; s < int'(SETS); s++) begin
          meta_q[w][s] <= '0;
        end
      end
    end else if (meta_we) begin
      meta_q[wr_way][idx] <= meta_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) line_q[wr_way][idx] <= line_wdata;
  end

  lru_ages #(
    .WAYS(WAYS),
    .SETS(SETS)
  ) u_lru (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_i      (idx),
    .touch_i    (touch),
    .touch_way_i(wr_way),
    .victim_o   (lru_victim)
  );

endmodule

// File: tb/tb_nway_cache.sv
// Randomized bench: a flat-memory golden model plus a timestamp-LRU cache model predict every response.
module tb_nway_cache;

  localparam int unsigned WAYS  = 4;
  localparam int unsigned SETS  = 16;
  localparam int unsigned WORDS = 4;
  localparam int unsigned LineW = 32 * WORDS;
  localparam int unsigned OB    = $clog2(WORDS) + 2;
  localparam int unsigned SB    = $clog2(SETS);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid_i, req_ready_o, req_we_i;
  logic [31:0]      req_addr_i, req_wdata_i;
  logic             resp_valid_o, resp_hit_o;
  logic [31:0]      resp_rdata_o;
  logic             mem_req_valid_o, mem_req_ready_i, mem_req_we_o;
  logic [31:0]      mem_req_addr_o;
  logic [LineW-1:0] mem_wdata_o;
  logic             mem_resp_valid_i;
  logic [LineW-1:0] mem_rdata_i;

  always #5 clk = ~clk;

  nway_cache #(
    .WAYS (WAYS),
    .SETS (SETS),
    .WORDS(WORDS)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_we_i        (req_we_i),
    .req_addr_i      (req_addr_i),
    .req_wdata_i     (req_wdata_i),
    .resp_valid_o    (resp_valid_o),
    .resp_hit_o      (resp_hit_o),
    .resp_rdata_o    (resp_rdata_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_we_o    (mem_req_we_o),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_resp_valid_i(mem_resp_valid_i),
    .mem_rdata_i     (mem_rdata_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Backing memory (what the DUT really wrote back) and golden architectural contents.
  logic [31:0] bmem [int unsigned];
  logic [31:0] gold [int unsigned];

  function automatic logic [31:0] dflt(input int unsigned wa);
    return (wa * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  function automatic logic [31:0] bmem_rd(input int unsigned wa);
    return bmem.exists(wa) ? bmem[wa] : dflt(wa);
  endfunction

  function automatic logic [31:0] gold_rd(input int unsigned wa);
    return gold.exists(wa) ? gold[wa] : dflt(wa);
  endfunction

  // Cache model: recency by timestamp, larger stamp means more recently used.
  bit          m_valid [WAYS][SETS];
  bit          m_dirty [WAYS][SETS];
  int unsigned m_tag   [WAYS][SETS];
  longint      m_stamp [WAYS][SETS];
  longint      now;

  task automatic model_reset();
    for (int w = 0; w < int'(WAYS); w++) begin
      for (int s = 0; s < int'(SETS); s++) begin
        m_valid[w][s] = 0;
        m_dirty[w][s] = 0;
        m_stamp[w][s] = -longint'(w);
      end
    end
    now = 0;
    gold.delete();
    foreach (bmem[k]) gold[k] = bmem[k];
  endtask

  task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              output bit exp_hit, output bit exp_wb,
                              output logic [31:0] exp_wb_addr);
    int unsigned s, t;
    int          way;
    s           = (addr >> OB) % SETS;
    t           = addr >> (OB + SB);
    exp_hit     = 0;
    exp_wb      = 0;
    exp_wb_addr = '0;
    way         = -1;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (m_valid[w][s] && m_tag[w][s] == t) begin
        exp_hit = 1;
        way     = w;
      end
    end
    if (!exp_hit) begin
      for (int w = 0; w < int'(WAYS); w++) if (!m_valid[w][s] && way < 0) way = w;
      if (way < 0) begin
        way = 0;
        for (int w = 1; w < int'(WAYS); w++) if (m_stamp[w][s] < m_stamp[way][s]) way = w;
      end
      exp_wb        = m_valid[way][s] && m_dirty[way][s];
      exp_wb_addr   = (m_tag[way][s] << (OB + SB)) | (s << OB);
      m_valid[way][s] = 1;
      m_tag[way][s]   = t;
      m_dirty[way][s] = 0;
    end
    if (we) begin
      m_dirty[way][s] = 1;
      gold[addr >> 2] = wd;
    end
    now++;
    m_stamp[way][s] = now;
  endtask

  logic [31:0] last_wb_addr;
  int          last_wb_cycles;

  task automatic do_reset();
    rst_n            = 1'b0;
    req_valid_i      = 1'b0;
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    #1;
    check_eq("rst_resp_valid", resp_valid_o, 0);
    check_eq("rst_mem_valid", mem_req_valid_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rel_req_ready", req_ready_o, 1);
    check_eq("rel_outputs", {resp_valid_o, resp_hit_o, mem_req_valid_o, mem_req_we_o}, 0);
    check_eq("rel_rdata", resp_rdata_o | mem_req_addr_o, 0);
    model_reset();
  endtask

  task automatic stray_pulse();
    @(posedge clk);
    #1;
    mem_resp_valid_i = 1'b1;
    mem_req_ready_i  = 1'b1;
    mem_rdata_i      = {WORDS{$urandom}};
    @(posedge clk);
    #1;
    mem_resp_valid_i = 1'b0;
    mem_req_ready_i  = 1'b0;
    check_eq("stray_quiet", {resp_valid_o, mem_req_valid_o, req_ready_o}, 3'b001);
  endtask

  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input int rdy_delay, input bit abort,
                         output logic got_hit, output logic [31:0] got_data);
    bit               exp_hit, exp_wb;
    logic [31:0]      exp_wb_addr, wb_addr, rf_addr;
    logic [LineW-1:0] wb_line;
    int               lat, wb_cycles, rf_cycles;
    bit               wb_stable, rf_pending, resp_sent, done, aborted;
    wb_cycles  = 0;
    rf_cycles  = 0;
    wb_stable  = 1;
    rf_pending = 0;
    resp_sent  = 0;
    done       = 0;
    aborted    = 0;
    got_hit    = 1'b0;
    got_data   = '0;
    wb_addr    = '0;
    rf_addr    = '0;
    wb_line    = '0;
    model_access(we, addr, wd, exp_hit, exp_wb, exp_wb_addr);

    @(posedge clk);
    #1;
    check_eq("idle_ready", {req_ready_o, resp_valid_o}, 2'b10);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wd;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    lat         = 1;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      mem_req_ready_i  = 1'b0;
      mem_resp_valid_i = 1'b0;
      if (resp_valid_o) begin
        got_hit  = resp_hit_o;
        got_data = resp_rdata_o;
        done     = 1;
      end else if (mem_req_valid_o && mem_req_we_o) begin
        wb_cycles++;
        if (wb_cycles == 1) begin
          wb_addr = mem_req_addr_o;
          wb_line = mem_wdata_o;
        end else if (mem_req_addr_o !== wb_addr || mem_wdata_o !== wb_line) begin
          wb_stable = 0;
        end
        if (wb_cycles > rdy_delay) begin
          mem_req_ready_i = 1'b1;
          for (int i = 0; i < int'(WORDS); i++) bmem[(wb_addr >> 2) + i] = wb_line[32*i +: 32];
        end
      end else if (mem_req_valid_o) begin
        rf_cycles++;
        rf_addr         = mem_req_addr_o;
        mem_req_ready_i = 1'b1;
        rf_pending      = 1;
      end else if (rf_pending && !resp_sent) begin
        if (abort) begin
          rst_n = 1'b0;
          #1;
          check_eq("abort_quiet", {resp_valid_o, mem_req_valid_o}, 0);
          repeat (2) @(posedge clk);
          #1;
          check_eq("abort_no_resp", resp_valid_o, 0);
          rst_n   = 1'b1;
          aborted = 1;
          done    = 1;
        end else begin
          mem_resp_valid_i = 1'b1;
          for (int i = 0; i < int'(WORDS); i++) mem_rdata_i[32*i +: 32] = bmem_rd((rf_addr >> 2) + i);
          resp_sent = 1;
        end
      end
    end
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    last_wb_addr     = wb_addr;
    last_wb_cycles   = wb_cycles;
    check_eq("txn_done", done, 1);
    if (aborted) begin
      @(posedge clk);
      #1;
      check_eq("abort_ready", {req_ready_o, resp_valid_o}, 2'b10);
      model_reset();
    end else if (done) begin
      check_eq("hit", got_hit, exp_hit);
      check_eq("rdata", got_data, gold_rd(addr >> 2));
      check_eq("wb_seen", wb_cycles != 0, exp_wb);
      if (exp_hit) begin
        check_eq("hit_latency", lat, 2);
        check_eq("hit_no_mem", wb_cycles + rf_cycles, 0);
      end else begin
        check_eq("rf_addr", rf_addr, addr & ~((32'd1 << OB) - 1));
        check_eq("rf_count", rf_cycles, 1);
      end
      if (exp_wb && wb_cycles != 0) begin
        check_eq("wb_addr", wb_addr, exp_wb_addr);
        check_eq("wb_cycles", wb_cycles, rdy_delay + 1);
        check_eq("wb_stable", wb_stable, 1);
        for (int i = 0; i < int'(WORDS); i++)
          check_eq("wb_data", wb_line[32*i +: 32], gold_rd((wb_addr >> 2) + i));
      end
    end
  endtask

  initial begin
    logic        h;
    logic [31:0] d;
    logic [31:0] a;
    req_valid_i      = 1'b0;
    req_we_i         = 1'b0;
    req_addr_i       = '0;
    req_wdata_i      = '0;
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_rdata_i      = '0;
    bmem[32'h40]     = 32'hA;
    bmem[32'h41]     = 32'hB;
    bmem[32'h42]     = 32'hC;
    bmem[32'h43]     = 32'hD;
    do_reset();

    run_txn(1'b0, 32'h100, 32'h0, 0, 0, h, d);
    check_eq("r029_miss_hit", h, 0);
    check_eq("r029_miss_data", d, 32'hA);
    run_txn(1'b0, 32'h104, 32'h0, 0, 0, h, d);
    check_eq("r029_hit", h, 1);
    check_eq("r029_hit_data", d, 32'hB);

    run_txn(1'b1, 32'h108, 32'hDEAD_BEEF, 0, 0, h, d);
    check_eq("r030_wr_hit", h, 1);
    run_txn(1'b0, 32'h108, 32'h0, 0, 0, h, d);
    check_eq("r030_rd_data", d, 32'hDEAD_BEEF);

    run_txn(1'b1, 32'h000, 32'h1111_0000, 0, 0, h, d);
    run_txn(1'b0, 32'h200, 32'h0, 0, 0, h, d);
    run_txn(1'b0, 32'h300, 32'h0, 0, 0, h, d);
    run_txn(1'b0, 32'h10C, 32'h0, 0, 0, h, d);
    run_txn(1'b0, 32'h204, 32'h0, 0, 0, h, d);
    run_txn(1'b0, 32'h308, 32'h0, 0, 0, h, d);
    run_txn(1'b0, 32'h400, 32'h0, 0, 0, h, d);
    check_eq("r031_evict_tag0", last_wb_addr, 32'h000);
    check_eq("r031_wb_once", last_wb_cycles, 1);

    run_txn(1'b0, 32'h500, 32'h0, 5, 0, h, d);
    check_eq("r032_evict_tag1", last_wb_addr, 32'h100);
    check_eq("r032_wb_hold", last_wb_cycles, 6);

    run_txn(1'b0, 32'h600, 32'h0, 0, 1, h, d);
    run_txn(1'b0, 32'h600, 32'h0, 0, 0, h, d);
    check_eq("r033_miss_after_rst", h, 0);

    stray_pulse();

    do_reset();
    for (int n = 0; n < 300; n++) begin
      a = ($urandom_range(0, 5) << (OB + SB)) | ($urandom_range(0, 1) << OB)
          | ($urandom_range(0, WORDS - 1) << 2) | $urandom_range(0, 3);
      run_txn(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3),
              ($urandom_range(0, 39) == 0), h, d);
      if (n % 37 == 36) stray_pulse();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
